// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 initiator for single register transactions.
//
// Sends one 16-bit frame, MSB first: {rw, addr zero-extended to 7 bits,
// wdata for a write or 0x00 for a read}. During the data byte of a read, the
// byte returned on MISO is captured into rdata. The SCLK half-period is
// CLK_DIV clk cycles, which is slow enough for a slave with 2-stage input
// synchronizers.
//
// Ports:
//   clk, rst             system clock; synchronous active-high reset
//   start, rw, addr,     transaction request; rw/addr/wdata are latched
//   wdata                when start is accepted in IDLE
//   busy                 transaction in progress
//   done                 one-cycle pulse when the transaction ends
//   rdata                read result; updated only when a read completes
//   spi_cs_n, spi_clk,   registered SPI outputs (SCLK idles low)
//   spi_mosi
//   spi_miso             serial data from the slave
module spi_reg_master #(
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int HC_W = $clog2(CLK_DIV);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic [4:0]      bcnt_q, bcnt_d;
  logic [15:0]     sh_q, sh_d;
  logic [15:0]     rx_q, rx_d;
  logic            rw_q, rw_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [6:0]      addr7;
  logic [15:0]     frame;
  logic            hc_last;

  assign addr7   = 7'(addr);
  assign frame   = {rw, addr7, (rw ? wdata : 8'h00)};
  assign hc_last = (hcnt_q == HC_MAX);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = frame;
          rw_d    = rw;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = frame[15];
          hcnt_d  = '0;
          bcnt_d  = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (hc_last) begin
          // First rising SCLK edge; MISO is sampled on the same clk edge.
          hcnt_d  = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[14:0], spi_miso};
          state_d = SHIFT;
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end

      SHIFT: begin
        if (!hc_last) begin
          hcnt_d = hcnt_q + HC_W'(1);
        end else begin
          hcnt_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit. Zeros shift in, so after
            // the 16th bit MOSI is already low.
            sclk_d = 1'b0;
            sh_d   = {sh_q[14:0], 1'b0};
            mosi_d = sh_q[14];
            bcnt_d = bcnt_q + 5'd1;
          end else if (bcnt_q == 5'd16) begin
            // The low phase of the last bit has completed.
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], spi_miso};
          end
        end
      end

      HOLD: begin
        mosi_d = 1'b0;
        if (hc_last) begin
          hcnt_d  = '0;
          cs_n_d  = 1'b1;
          state_d = GAP;
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end

      GAP: begin
        if (hc_last) begin
          hcnt_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          // The command byte (rx[15:8]) is discarded.
          if (!rw_q) begin
            rdata_d = rx_q[7:0];
          end
          state_d = DONE;
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end

      DONE: begin
        // start is not sampled here, so back-to-back frames keep CS_n high
        // for at least CLK_DIV+2 cycles.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Frame data registers; these need no reset because they are loaded on
  // start acceptance before they are used.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    rx_q <= rx_d;
    rw_q <= rw_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
module tb_spi_reg_master;

  localparam int ADDR_W  = 4;
  localparam int CLK_DIV = 4;
  localparam int LAT     = 35 * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              busy;
  logic              done;
  logic [7:0]        rdata;
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso = 1'b0;

  spi_reg_master #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [15:0] frame_q[$];
  logic [7:0]  done_q[$];

  // Slave model: register file behind a mode-0 SPI port
  logic [7:0]  sreg[128];
  logic        s_prev_cs   = 1'b1;
  logic        s_prev_sclk = 1'b0;
  logic [15:0] s_cap;
  logic [7:0]  s_cmd;
  int          s_rises;
  int          s_falls;
  int          partial = 0;
  logic        m1 = 1'b0, m2 = 1'b0;

  always @(negedge clk) begin
    logic       nb;
    logic [7:0] v;
    logic [15:0] ef;
    nb = 1'b0;
    if (!spi_cs_n && s_prev_cs) begin
      s_rises = 0;
      s_falls = 0;
      s_cap   = 16'h0;
      s_cmd   = 8'h0;
    end
    if (!spi_cs_n) begin
      if (spi_clk && !s_prev_sclk) begin
        s_cap = {s_cap[14:0], spi_mosi};
        s_rises++;
        if (s_rises == 8) s_cmd = s_cap[7:0];
      end
      if (!spi_clk && s_prev_sclk) s_falls++;
      if (s_falls >= 8 && s_falls <= 15 && !s_cmd[7]) begin
        v  = sreg[s_cmd[6:0]];
        nb = v[15 - s_falls];
      end
    end
    if (spi_cs_n && !s_prev_cs) begin
      if (s_rises == 16) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame", {16'h0, s_cap}, 32'hFFFF_FFFF);
        end else begin
          ef = frame_q.pop_front();
          check("mosi_frame", {16'h0, s_cap}, {16'h0, ef});
        end
        if (s_cap[15]) sreg[s_cap[14:8]] = s_cap[7:0];
      end else begin
        partial++;
      end
    end
    m1          <= nb;
    m2          <= m1;
    spi_miso    <= m2;
    s_prev_cs   = spi_cs_n;
    s_prev_sclk = spi_clk;
  end

  // Done monitor
  logic prev_busy = 1'b0;
  logic prev_cs   = 1'b1;
  int   start_cyc = 0;
  int   last_done = -1;
  int   n_accept  = 0;
  int   cs_hi_run = 0;
  int   b2b_frames = 0;
  bit   b2b = 1'b0;

  always @(negedge clk) begin
    logic [7:0] er;
    if (busy && !prev_busy) begin
      start_cyc = cyc;
      n_accept++;
    end
    if (!spi_cs_n && prev_cs) begin
      if (b2b && b2b_frames > 0)
        check("cs_high_gap_ge_div_plus2", {31'h0, (cs_hi_run >= CLK_DIV + 2)}, 32'h1);
      if (b2b) b2b_frames++;
      cs_hi_run = 0;
    end else if (spi_cs_n) begin
      cs_hi_run++;
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        er = done_q.pop_front();
        check("rdata_at_done", {24'h0, rdata}, {24'h0, er});
        check("busy_low_at_done", {31'h0, busy}, 32'h0);
        check("done_latency", cyc - start_cyc, LAT);
        if (b2b && last_done >= 0)
          check("done_spacing", cyc - last_done, LAT + 2);
      end
      last_done = cyc;
    end
    prev_busy = busy;
    prev_cs   = spi_cs_n;
  end

  task automatic issue(input logic irw, input logic [ADDR_W-1:0] iaddr, input logic [7:0] iwd,
                       input logic [15:0] eframe, input logic [7:0] erd);
    @(negedge clk);
    start = 1'b1;
    rw    = irw;
    addr  = iaddr;
    wdata = iwd;
    frame_q.push_back(eframe);
    done_q.push_back(erd);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((done_q.size() != 0 || frame_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending_done=%0d pending_frames=%0d", done_q.size(), frame_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, {31'h0, spi_cs_n}, 32'h1);
    check({tag, "_sclk"}, {31'h0, spi_clk}, 32'h0);
    check({tag, "_mosi"}, {31'h0, spi_mosi}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_rdata"}, {24'h0, rdata}, 32'h0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 128; i++) sreg[i] = 8'h00;
    sreg[3] = 8'h3C;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xA5 to 0x5; rdata stays 0x00
    issue(1'b1, 4'h5, 8'hA5, 16'h85A5, 8'h00);
    drain();

    // Read 0x3; slave returns 0x3C
    issue(1'b0, 4'h3, 8'hFF, 16'h0300, 8'h3C);
    drain();

    // Starts during an active write are ignored
    issue(1'b1, 4'h2, 8'h77, 16'h8277, 8'h3C);
    repeat (8) @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 4'h3; wdata = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 4'h7; wdata = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high: three back-to-back frames
    b2b        = 1'b1;
    b2b_frames = 0;
    last_done  = -1;
    base       = n_accept;
    for (int k = 0; k < 3; k++) begin
      frame_q.push_back(16'h8111);
      done_q.push_back(8'h3C);
    end
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 4'h1; wdata = 8'h11;
    n = 0;
    while (n_accept < base + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL b2b_accept_timeout accepted=%0d required=3", n_accept - base);
    end
    drain();
    b2b = 1'b0;

    // Reset in the middle of a read
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 4'h3;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_abort_busy", {31'h0, busy}, 32'h0);

    // Read after abort
    issue(1'b0, 4'h3, 8'h00, 16'h0300, 8'h3C);
    drain();

    // Write then read back register 0
    issue(1'b1, 4'h0, 8'h5A, 16'h805A, 8'h3C);
    drain();
    issue(1'b0, 4'h0, 8'h00, 16'h0000, 8'h5A);
    drain();

    check("partial_frames", partial, 1);
    check("frames_pending", frame_q.size(), 0);
    check("dones_pending", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI initiator for the register-access SPI port of the peripheral test harness.
- Issues single register write or read transactions (ADDR_W-bit address, 8-bit data) to the harness's SPI register slave.
- Used by the on-chip/FPGA test driver and as the bench-side master model for harness verification.
- Generates CS_n, SCLK and MOSI, and samples MISO. Paced slowly enough for the slave's 2-stage input synchronizers.

Parameters:
- ADDR_W, 4, register address width; legal range 1..7.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal minimum 4 (covers 2-stage slave sync plus slave register delay).

Ports:
- clk      input   1       system clock; all logic on rising edge
- rst      input   1       synchronous reset, active high
- start    input   1       request a transaction; sampled only when busy=0
- rw       input   1       1=write, 0=read; latched at start
- addr     input   ADDR_W  register address; latched at start
- wdata    input   8       write data; latched at start
- busy     output  1       high from the cycle after start acceptance until done
- done     output  1       one-cycle pulse at transaction end
- rdata    output  8       read result; updated only at done of a read
- spi_cs_n output  1       chip select, active low
- spi_clk  output  1       SCLK, idle low (mode 0)
- spi_mosi output  1       serial data out, MSB first
- spi_miso input   1       serial data in from slave

Behaviour:
- Reset (rst=1 at a clk edge): spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0x00, FSM=IDLE, counters=0.
- Reset mid-transaction: all of the above on the same edge. CS_n rises immediately, no done pulse, rdata unchanged-to-0 per reset.
- Frame: 16 bits, MSB first.
  - bit15 = rw.
  - bits14..8 = address zero-extended to 7 bits.
  - bits7..0 = wdata for a write, 0x00 for a read.
  - Example: write addr 0x5, data 0xA5 -> 0x85A5. Read addr 0x3 -> 0x0300.
- SPI mode 0:
  - MOSI changes only while SCLK is low, at the start of each low phase.
  - Slave samples on the SCLK rising edge.
  - Master samples MISO on the clk edge that drives SCLK high, i.e. at the end of the low phase.
- FSM states and transitions:
  - IDLE: if start=1, latch rw/addr/wdata into a 16-bit shift register; next edge: busy=1, spi_cs_n=0, spi_mosi=bit15 -> SETUP.
  - SETUP: CS low, SCLK low for CLK_DIV cycles -> SHIFT.
  - SHIFT: 16 bits. Each bit is SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - On the rising transition, shift MISO into rx[0].
    - On each falling transition, present the next MOSI bit.
    - After the 16th falling edge -> HOLD.
  - HOLD: CS low, SCLK low, CLK_DIV cycles; spi_mosi=0 -> GAP.
  - GAP: spi_cs_n=1 for CLK_DIV cycles. Guarantees minimum CS_n high time before any next frame. On the final cycle -> DONE.
  - DONE: done=1, busy=0 for exactly one cycle; for a read, rdata <= rx[7:0] on this edge -> IDLE.
- Latency: the edge sampling start=1 to the edge asserting done is exactly 35*CLK_DIV cycles (140 at CLK_DIV=4).
- Busy/start rules:
  - start while busy=1 is ignored and not queued.
  - start held high continuously: a new transaction is accepted in the IDLE cycle following done. CS_n high for ≥CLK_DIV+2 cycles between frames.
  - Input changes while busy have no effect.
- Bits 15..8 of rx (MISO during the command byte) are discarded.
- Write transactions never modify rdata.
- SCLK, CS_n and MOSI are registered outputs (glitch-free). No combinational path from any input to any output.
- Counters:
  - Half-period counter width is ceil(log2(CLK_DIV)).
  - Bit counter is 5 bits, counting 0..16; no wrap beyond 16.

Test Plan:
- Write 0xA5 to addr 0x5, CLK_DIV=4 -> exactly 16 SCLK rising edges with CS_n low; slave model captures MOSI=0x85A5; done pulses 140 cycles after start; rdata stays 0x00.
- Read addr 0x3 with slave model driving 0x3C on MISO (mode 0, 3-cycle response delay) -> MOSI=0x0300, rdata=0x3C at done, busy low same cycle.
- start pulsed again at cycles 10 and 60 of an active transaction -> ignored; exactly one done pulse; only one frame on the bus.
- start held high for 400 cycles -> back-to-back frames; CS_n high ≥6 cycles between frames; done pulses exactly 142 cycles apart.
- rst asserted at cycle 50 of a read -> next edge: CS_n=1, SCLK=0, MOSI=0, busy=0, rdata=0x00; no done; a subsequent read of 0x3C completes correctly.
- Integration with the harness: write 0x5A to peripheral register 0x0, then read 0x0 -> rdata=0x5A (peripheral's read-back value).
